// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler
//   Arbitrates two requesters onto one shared multiply/divide unit. A granted
//   request is latched, a single start pulse is issued, and the scheduler then
//   waits for the unit's result (or gives up after TIMEOUT cycles). It finishes
//   by returning a one-cycle response tagged with the requester id.
//
// Ports
//   clk, reset              clock; synchronous active-low reset
//   reqN_valid/op/a/b       requester N operation (op 0 = mul, 1 = div)
//   reqN_ready              combinational grant, high only in IDLE
//   md_ctrl_MULT/DIV        one-cycle start pulse to the shared unit
//   md_operandA/B           latched operands to the shared unit
//   md_resultRDY/result/exception  result handshake from the shared unit
//   rsp_valid/id/result/exception  response strobe and held response data
//   busy                    scheduler is not IDLE
//
// TIMEOUT must lie in 2..63 so that the 6-bit WAIT counter can reach TIMEOUT-1.

module multdiv_scheduler #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  output logic        busy
);

  localparam int          NUM_REQ  = 2;
  localparam logic [5:0]  CNT_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  state_t                    state_q, state_d;
  logic [5:0]                cnt_q;
  logic                      last_gnt_q;
  md_req_t                   op_q;
  logic                      id_q;
  logic [31:0]               res_q;
  logic                      exc_q;
  logic                      rsp_id_q;

  logic [NUM_REQ-1:0]        req_valid;
  md_req_t [NUM_REQ-1:0]     req;
  logic                      gnt_id;
  logic                      xfer;
  logic                      wait_exit;

  assign req_valid = {req1_valid, req0_valid};
  assign req[0]    = {req0_op, req0_a, req0_b};
  assign req[1]    = {req1_op, req1_a, req1_b};

  // Round-robin: on a tie the requester not granted last time wins; a lone
  // valid requester always wins. gnt_id is only meaningful when xfer is high.
  always_comb begin
    gnt_id = req_valid[1];
    if (&req_valid) gnt_id = ~last_gnt_q;
  end

  // Ready is gated by reset so nothing handshakes during a reset cycle.
  assign xfer       = reset && (state_q == IDLE) && (|req_valid);
  assign req0_ready = xfer && !gnt_id;
  assign req1_ready = xfer &&  gnt_id;

  // Unit result wins over the timeout when both occur in the same cycle.
  assign wait_exit = md_resultRDY || (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = START;
      START:   state_d = WAIT;  // md_resultRDY deliberately not looked at here
      WAIT:    if (wait_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;   // requester 0 wins the first tie
      op_q       <= '0;
      id_q       <= 1'b0;
      res_q      <= '0;
      exc_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Only the granted requester's operands are sampled.
      if (xfer) begin
        op_q       <= req[gnt_id];
        id_q       <= gnt_id;
        last_gnt_q <= gnt_id;
      end

      // Counter sits at zero outside WAIT, so it is clear on WAIT entry.
      if (state_q == WAIT) cnt_q <= cnt_q + 6'd1;
      else                 cnt_q <= '0;

      // Response data is captured on the way into DONE and then held until
      // the next capture, independent of later grants.
      if (state_q == WAIT && wait_exit) begin
        res_q    <= md_resultRDY ? md_result    : 32'd0;
        exc_q    <= md_resultRDY ? md_exception : 1'b1;
        rsp_id_q <= id_q;
      end
    end
  end

  assign md_ctrl_MULT  = reset && (state_q == START) && !op_q.op;
  assign md_ctrl_DIV   = reset && (state_q == START) &&  op_q.op;
  assign md_operandA   = op_q.a;
  assign md_operandB   = op_q.b;
  assign rsp_valid     = reset && (state_q == DONE);
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = res_q;
  assign rsp_exception = exc_q;
  assign busy          = reset && (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Bench for multdiv_scheduler: plays the shared mul/div unit and both
// requesters. Table vectors, a reset-abort sequence, then random traffic
// against a transaction-level model (round-robin grant, unit arithmetic,
// fixed latency/timeout rules).

module tb_multdiv_scheduler;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_op, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_op, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_operandA, md_operandB;
  logic        md_resultRDY, md_exception;
  logic [31:0] md_result;
  logic        rsp_valid, rsp_id, rsp_exception, busy;
  logic [31:0] rsp_result;

  always #5 clk = ~clk;

  multdiv_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_resultRDY(md_resultRDY), .md_result(md_result), .md_exception(md_exception),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_exception(rsp_exception), .busy(busy)
  );

  typedef struct {
    logic        v0, op0;
    logic [31:0] a0, b0;
    logic        v1, op1;
    logic [31:0] a1, b1;
    int          dly;       // WAIT cycle index of unit result; -1 = never
    logic        rs;        // also raise md_resultRDY during START
    logic [31:0] res_in;
    logic        ex_in;
    logic        exp_id;
    logic [31:0] exp_res;
    logic        exp_ex;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        mdl_last;
  logic [31:0] mdl_prev_res;
  logic        mdl_prev_ex, mdl_prev_id;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int v0, input int op0, input logic [31:0] a0, input logic [31:0] b0,
                              input int v1, input int op1, input logic [31:0] a1, input logic [31:0] b1,
                              input int dly, input int rs, input logic [31:0] res_in, input int ex_in,
                              input int exp_id, input logic [31:0] exp_res, input int exp_ex);
    vec_t r;
    r.v0 = v0[0]; r.op0 = op0[0]; r.a0 = a0; r.b0 = b0;
    r.v1 = v1[0]; r.op1 = op1[0]; r.a1 = a1; r.b1 = b1;
    r.dly = dly; r.rs = rs[0]; r.res_in = res_in; r.ex_in = ex_in[0];
    r.exp_id = exp_id[0]; r.exp_res = exp_res; r.exp_ex = exp_ex[0];
    return r;
  endfunction

  // Starts and ends at posedge+1 with the DUT in IDLE.
  task automatic txn(input vec_t v);
    logic        g;
    logic        eop;
    logic [31:0] ea, eb;
    int          k;
    g   = v.exp_id;
    eop = g ? v.op1 : v.op0;
    ea  = g ? v.a1  : v.a0;
    eb  = g ? v.b1  : v.b0;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    md_resultRDY = 1'b0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_rsp_valid", rsp_valid, 1'b0);
    chk32("rsp_result_hold", rsp_result, mdl_prev_res);
    chk1("rsp_exc_hold", rsp_exception, mdl_prev_ex);
    chk1("rsp_id_hold", rsp_id, mdl_prev_id);
    chk1("ready0", req0_ready, g == 1'b0);
    chk1("ready1", req1_ready, g == 1'b1);
    // START: granted requester drops, the other holds its request
    @(posedge clk); #1;
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    md_resultRDY = v.rs; md_result = 32'hdead_beef; md_exception = 1'b1;
    @(negedge clk);
    chk1("start_mult", md_ctrl_MULT, !eop);
    chk1("start_div", md_ctrl_DIV, eop);
    chk32("start_opA", md_operandA, ea);
    chk32("start_opB", md_operandB, eb);
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", req0_ready | req1_ready, 1'b0);
    // WAIT: cycle k counted from WAIT entry
    @(posedge clk); #1;
    k = 0;
    while (1) begin
      md_resultRDY = (k == v.dly);
      md_result = v.res_in; md_exception = v.ex_in;
      @(negedge clk);
      chk1("wait_rsp_valid", rsp_valid, 1'b0);
      chk1("wait_ctrl", md_ctrl_MULT | md_ctrl_DIV, 1'b0);
      if (k == v.dly || k == TIMEOUT - 1) break;
      @(posedge clk); #1;
      k++;
    end
    // DONE
    @(posedge clk); #1;
    md_resultRDY = 1'b0; md_result = 32'h0; md_exception = 1'b0;
    @(negedge clk);
    chk1("done_rsp_valid", rsp_valid, 1'b1);
    chk1("done_rsp_id", rsp_id, g);
    chk32("done_rsp_result", rsp_result, v.exp_res);
    chk1("done_rsp_exc", rsp_exception, v.exp_ex);
    chk32("done_opA", md_operandA, ea);
    chk1("done_busy", busy, 1'b1);
    mdl_prev_res = v.exp_res; mdl_prev_ex = v.exp_ex; mdl_prev_id = g;
    mdl_last = g;
    @(posedge clk); #1;
  endtask

  vec_t        tbl[10];
  logic        pv[2], pop[2];
  logic [31:0] pa[2], pb[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1, 0, 3, 4,     1, 0, 9, 9,  2, 0, 12, 0,  0, 12, 0);  // tie, req0 first
    tbl[1] = mk(1, 1, 100, 7,   1, 0, 9, 9,  4, 0, 81, 0,  1, 81, 0);  // tie again, req1
    tbl[2] = mk(1, 1, 100, 7,   0, 0, 0, 0,  1, 0, 14, 0,  0, 14, 0);
    tbl[3] = mk(1, 0, 7, 6,     0, 0, 0, 0, 16, 0, 42, 0,  0, 42, 0);  // result 17 cycles after start
    tbl[4] = mk(0, 0, 0, 0,     1, 1, 5, 0,  3, 0, 0, 1,   1, 0, 1);   // divide by zero
    tbl[5] = mk(1, 0, 1, 1,     0, 0, 0, 0, -1, 0, 0, 0,   0, 0, 1);   // timeout
    tbl[6] = mk(0, 0, 0, 0,     1, 1, 50, 5, TIMEOUT-1, 0, 10, 0, 1, 10, 0); // result beats timeout
    tbl[7] = mk(1, 1, 9, 3,     0, 0, 0, 0,  0, 1, 3, 0,   0, 3, 0);   // RDY during START ignored
    tbl[8] = mk(0, 0, 0, 0,     1, 0, 2, 8,  5, 1, 16, 0,  1, 16, 0);
    tbl[9] = mk(1, 0, 11, 2,    1, 0, 13, 3, 1, 0, 22, 0,  0, 22, 0);  // tie after req1 last

    // reset with both requesting: nothing may handshake
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    md_resultRDY = 1'b0; md_result = 32'h0; md_exception = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_ready", req0_ready | req1_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ctrl", md_ctrl_MULT | md_ctrl_DIV, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_result", rsp_result, 32'h0);
    chk32("rst_opA", md_operandA, 32'h0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    mdl_last = 1'b1; mdl_prev_res = 32'h0; mdl_prev_ex = 1'b0; mdl_prev_id = 1'b0;

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // reset while in WAIT aborts silently
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd5; req0_b = 32'd5;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk1("wrst_busy", busy, 1'b0);
    chk1("wrst_rsp_valid", rsp_valid, 1'b0);
    chk1("wrst_ready", req0_ready | req1_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; md_resultRDY = 1'b1;
    @(negedge clk);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_rsp_valid", rsp_valid, 1'b0);
    chk32("arst_rsp_result", rsp_result, 32'h0);
    chk32("arst_opA", md_operandA, 32'h0);
    @(posedge clk); #1;
    md_resultRDY = 1'b0;
    @(negedge clk);
    chk1("arst_stray_rdy", rsp_valid, 1'b0);
    @(posedge clk); #1;
    mdl_last = 1'b1; mdl_prev_res = 32'h0; mdl_prev_ex = 1'b0; mdl_prev_id = 1'b0;
    txn(mk(1, 1, 64, 8, 1, 0, 6, 6, 2, 0, 8, 0, 0, 8, 0));

    // random traffic: pending requests persist until granted
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      logic g;
      int   r;
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1; pop[i] = 1'($urandom_range(0, 1));
          pa[i] = $urandom; pb[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        end
      end
      if (!pv[0] && !pv[1]) begin
        pv[0] = 1'b1; pop[0] = 1'b0; pa[0] = $urandom; pb[0] = $urandom;
      end
      g = (pv[0] && pv[1]) ? !mdl_last : pv[1];
      v.v0 = pv[0]; v.op0 = pop[0]; v.a0 = pa[0]; v.b0 = pb[0];
      v.v1 = pv[1]; v.op1 = pop[1]; v.a1 = pa[1]; v.b1 = pb[1];
      r = $urandom_range(0, 9);
      if (r == 0)      v.dly = -1;
      else if (r == 1) v.dly = TIMEOUT - 1;
      else             v.dly = $urandom_range(0, 12);
      v.rs = 1'($urandom_range(0, 1));
      if (pop[g]) begin
        v.res_in = (pb[g] == 32'h0) ? 32'h0 : pa[g] / pb[g];
        v.ex_in  = (pb[g] == 32'h0);
      end else begin
        v.res_in = pa[g] * pb[g];
        v.ex_in  = 1'b0;
      end
      v.exp_id  = g;
      v.exp_res = (v.dly < 0) ? 32'h0 : v.res_in;
      v.exp_ex  = (v.dly < 0) ? 1'b1 : v.ex_in;
      txn(v);
      pv[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
